// File: rtl/rv32i_types.sv
// Shared rename/retire constants for the rv32i out-of-order core.
// Free-list sizing and pointer type live here alongside the register-file widths.
package rv32i_types;

   localparam int PR_WIDTH = 6;
   localparam int RRF_NUM  = 32;
   localparam int PR_NUM   = 64;
   localparam int FL_DEPTH = PR_NUM - RRF_NUM;

   typedef logic [$clog2(FL_DEPTH):0] fl_ptr_t;

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical registers feeding rename, refilled by retire.
// A committed read pointer lets a mispredict flush rewind all speculative pops in one cycle.
module free_list
   import rv32i_types::*;
#(
   parameter int PR_WIDTH_P = PR_WIDTH,
   parameter int PR_NUM_P   = PR_NUM,
   parameter int RRF_NUM_P  = RRF_NUM,
   parameter int DEPTH      = PR_NUM_P - RRF_NUM_P
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enqueue,
   input  logic [PR_WIDTH_P-1:0]     old_phys_reg_index,
   input  logic                      dequeue,
   output logic [PR_WIDTH_P-1:0]     free_preg,
   output logic                      free_valid,
   input  logic                      commit_alloc,
   input  logic                      branch,
   output logic [$clog2(DEPTH):0]    free_count
);

   localparam int AW = $clog2(DEPTH);
   typedef logic [AW:0] ptr_t;

   logic [PR_WIDTH_P-1:0] fl [DEPTH];
   ptr_t wr_ptr, rd_ptr, cm_ptr, cm_next;
   logic empty, full, do_deq, do_enq;

   assign empty   = (rd_ptr == wr_ptr);
   assign full    = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
   assign do_deq  = dequeue && !empty && !branch;
   assign do_enq  = enqueue && !full;
   assign cm_next = cm_ptr + ptr_t'(commit_alloc);

   assign free_preg  = fl[rd_ptr[AW-1:0]];
   assign free_valid = !empty;
   assign free_count = wr_ptr - rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            fl[i] <= PR_WIDTH_P'(RRF_NUM_P + i);
         rd_ptr <= '0;
         cm_ptr <= '0;
         wr_ptr <= ptr_t'(DEPTH);
      end else begin
         if (do_enq) begin
            fl[wr_ptr[AW-1:0]] <= old_phys_reg_index;
            wr_ptr             <= wr_ptr + ptr_t'(1);
         end
         cm_ptr <= cm_next;
         // Flush rewinds to the committed pointer including this cycle's commit.
         rd_ptr <= branch ? cm_next : rd_ptr + ptr_t'(do_deq);
      end
   end

`ifndef SYNTHESIS
   logic remapped;

   always_ff @(posedge clk) begin
      if (rst) remapped <= 1'b0;
      else if (do_deq) remapped <= 1'b1;
      if (!rst) begin
         assert (!(enqueue && full))
            else $error("free_list: enqueue while full");
         assert (ptr_t'(rd_ptr - cm_ptr) <= ptr_t'(DEPTH))
            else $error("free_list: cm_ptr ahead of rd_ptr");
         assert (!(enqueue && !remapped && old_phys_reg_index < PR_WIDTH_P'(RRF_NUM_P)))
            else $error("free_list: architectural preg freed before any remap");
      end
   end
`endif

endmodule
